// File: rtl/fir_scie_sequencer.sv
// Command sequencer that turns coefficient writes and a sample stream into SCIE FIR
// instruction beats and buffers the filter outputs. Define FIR_SEQ_PERF_EN for perf counters.
module fir_scie_sequencer #(
  parameter int XLEN       = 32,
  parameter int NTAPS      = 5,
  parameter int IDXW       = 3,
  parameter int PUSH_GAP   = 1,
  parameter int RD_LATENCY = 1,
  parameter int FIFO_DEPTH = 4
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            io_cfg_valid,
  output logic            io_cfg_ready,
  input  logic [IDXW-1:0] io_cfg_idx,
  input  logic [XLEN-1:0] io_cfg_coef,
  input  logic            io_in_valid,
  output logic            io_in_ready,
  input  logic [XLEN-1:0] io_in_sample,
  output logic            io_out_valid,
  input  logic            io_out_ready,
  output logic [XLEN-1:0] io_out_result,
  output logic            io_scie_valid,
  output logic [31:0]     io_scie_insn,
  output logic [XLEN-1:0] io_scie_rs1,
  output logic [XLEN-1:0] io_scie_rs2,
  input  logic [XLEN-1:0] io_scie_rd,
  output logic            io_err
`ifdef FIR_SEQ_PERF_EN
  ,
  output logic [31:0]     io_perf_results,
  output logic [31:0]     io_perf_stalls
`endif
);

  localparam logic [31:0] INSN_LOAD = 32'h0000_000B;
  localparam logic [31:0] INSN_PUSH = 32'h0000_002B;
  localparam logic [31:0] INSN_READ = 32'h0000_005B;

  localparam int CNT_W  = 16;
  localparam int PTR_W  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int FCNT_W = $clog2(FIFO_DEPTH + 1);

  localparam logic [CNT_W-1:0]  GAP_LAST  = CNT_W'((PUSH_GAP > 0) ? PUSH_GAP - 1 : 0);
  localparam logic [CNT_W-1:0]  WAIT_LAST = CNT_W'((RD_LATENCY > 0) ? RD_LATENCY - 1 : 0);
  localparam logic [31:0]       NTAPS_U   = 32'(NTAPS);
  localparam logic [FCNT_W-1:0] FIFO_FULL = FCNT_W'(FIFO_DEPTH);
  localparam logic [PTR_W-1:0]  PTR_LAST  = PTR_W'(FIFO_DEPTH - 1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_PUSH,
    ST_GAP,
    ST_READ,
    ST_WAIT
  } state_t;

  state_t            state_reg, state_next;
  logic [CNT_W-1:0]  cnt_reg, cnt_next;
  logic              en_reg;
  logic              err_reg, err_next;
  logic              scie_valid_reg, scie_valid_next;
  logic [31:0]       scie_insn_reg, scie_insn_next;
  logic [XLEN-1:0]   scie_rs1_reg, scie_rs1_next;
  logic [XLEN-1:0]   scie_rs2_reg, scie_rs2_next;

  logic [XLEN-1:0]   fifo_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr_reg, rd_ptr_reg;
  logic [FCNT_W-1:0] fifo_count_reg;

  logic cfg_fire, in_fire, idx_ok, capture, pop;

  assign idx_ok   = 32'(io_cfg_idx) < NTAPS_U;
  assign cfg_fire = io_cfg_valid && io_cfg_ready;
  assign in_fire  = io_in_valid && io_in_ready;
  assign pop      = io_out_valid && io_out_ready;

  // Readys are held low for one cycle after reset release by the enable flag.
  assign io_cfg_ready = en_reg && (state_reg == ST_IDLE);
  assign io_in_ready  = en_reg && (state_reg == ST_IDLE) && !io_cfg_valid &&
                        (fifo_count_reg < FIFO_FULL);

  assign io_scie_valid = scie_valid_reg;
  assign io_scie_insn  = scie_insn_reg;
  assign io_scie_rs1   = scie_rs1_reg;
  assign io_scie_rs2   = scie_rs2_reg;
  assign io_err        = err_reg;
  assign io_out_valid  = (fifo_count_reg != '0);
  assign io_out_result = fifo_mem[rd_ptr_reg];

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_reg      <= ST_IDLE;
      cnt_reg        <= '0;
      en_reg         <= 1'b0;
      err_reg        <= 1'b0;
      scie_valid_reg <= 1'b0;
      scie_insn_reg  <= '0;
      scie_rs1_reg   <= '0;
      scie_rs2_reg   <= '0;
    end else begin
      state_reg      <= state_next;
      cnt_reg        <= cnt_next;
      en_reg         <= 1'b1;
      err_reg        <= err_next;
      scie_valid_reg <= scie_valid_next;
      scie_insn_reg  <= scie_insn_next;
      scie_rs1_reg   <= scie_rs1_next;
      scie_rs2_reg   <= scie_rs2_next;
    end
  end

  // Beat registers are loaded on the transition into a beat state, so the beat
  // is on the wire for exactly the cycle the FSM spends in that state.
  always_comb begin
    state_next      = state_reg;
    err_next        = err_reg;
    scie_valid_next = 1'b0;
    scie_insn_next  = '0;
    scie_rs1_next   = '0;
    scie_rs2_next   = '0;
    capture         = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        if (cfg_fire) begin
          if (idx_ok) begin
            state_next      = ST_LOAD;
            scie_valid_next = 1'b1;
            scie_insn_next  = INSN_LOAD;
            scie_rs1_next   = io_cfg_coef;
            scie_rs2_next   = XLEN'(io_cfg_idx);
          end else begin
            err_next = 1'b1;
          end
        end else if (in_fire) begin
          state_next      = ST_PUSH;
          scie_valid_next = 1'b1;
          scie_insn_next  = INSN_PUSH;
          scie_rs1_next   = io_in_sample;
        end
      end
      ST_LOAD: state_next = ST_IDLE;
      ST_PUSH: begin
        if (PUSH_GAP > 0) begin
          state_next = ST_GAP;
        end else begin
          state_next      = ST_READ;
          scie_valid_next = 1'b1;
          scie_insn_next  = INSN_READ;
        end
      end
      ST_GAP: begin
        if (cnt_reg == GAP_LAST) begin
          state_next      = ST_READ;
          scie_valid_next = 1'b1;
          scie_insn_next  = INSN_READ;
        end
      end
      ST_READ: state_next = ST_WAIT;
      ST_WAIT: begin
        if (cnt_reg == WAIT_LAST) begin
          capture    = 1'b1;
          state_next = ST_IDLE;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // Dwell counter restarts on every state change and only runs in GAP/WAIT.
  always_comb begin
    cnt_next = '0;
    if ((state_next == state_reg) && (state_reg == ST_GAP || state_reg == ST_WAIT))
      cnt_next = cnt_reg + CNT_W'(1);
  end

  always_ff @(posedge clock) begin
    if (capture)
      fifo_mem[wr_ptr_reg] <= io_scie_rd;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wr_ptr_reg     <= '0;
      rd_ptr_reg     <= '0;
      fifo_count_reg <= '0;
    end else begin
      if (capture)
        wr_ptr_reg <= (wr_ptr_reg == PTR_LAST) ? '0 : wr_ptr_reg + PTR_W'(1);
      if (pop)
        rd_ptr_reg <= (rd_ptr_reg == PTR_LAST) ? '0 : rd_ptr_reg + PTR_W'(1);
      case ({capture, pop})
        2'b10:   fifo_count_reg <= fifo_count_reg + FCNT_W'(1);
        2'b01:   fifo_count_reg <= fifo_count_reg - FCNT_W'(1);
        default: fifo_count_reg <= fifo_count_reg;
      endcase
    end
  end

`ifdef FIR_SEQ_PERF_EN
  logic [31:0] perf_results_reg;
  logic [31:0] perf_stalls_reg;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      perf_results_reg <= '0;
      perf_stalls_reg  <= '0;
    end else begin
      if (capture)
        perf_results_reg <= perf_results_reg + 32'd1;
      if (io_in_valid && !io_in_ready)
        perf_stalls_reg <= perf_stalls_reg + 32'd1;
    end
  end

  assign io_perf_results = perf_results_reg;
  assign io_perf_stalls  = perf_stalls_reg;
`endif

endmodule

// File: tb/tb_fir_scie_sequencer.sv
// Scoreboard bench for fir_scie_sequencer with an attached behavioural SCIE FIR unit.
module tb_fir_scie_sequencer;
  localparam int XLEN     = 32;
  localparam int NTAPS    = 5;
  localparam int IDXW     = 3;
  localparam int PUSH_GAP = 1;
  localparam logic [31:0] I_LOAD = 32'h0B;
  localparam logic [31:0] I_PUSH = 32'h2B;
  localparam logic [31:0] I_READ = 32'h5B;

  logic            clock = 1'b0;
  logic            reset = 1'b0;
  logic            io_cfg_valid = 1'b0;
  logic            io_cfg_ready;
  logic [IDXW-1:0] io_cfg_idx = '0;
  logic [XLEN-1:0] io_cfg_coef = '0;
  logic            io_in_valid = 1'b0;
  logic            io_in_ready;
  logic [XLEN-1:0] io_in_sample = '0;
  logic            io_out_valid;
  logic            io_out_ready = 1'b0;
  logic [XLEN-1:0] io_out_result;
  logic            io_scie_valid;
  logic [31:0]     io_scie_insn;
  logic [XLEN-1:0] io_scie_rs1;
  logic [XLEN-1:0] io_scie_rs2;
  logic [XLEN-1:0] io_scie_rd;
  logic            io_err;
`ifdef FIR_SEQ_PERF_EN
  logic [31:0]     io_perf_results;
  logic [31:0]     io_perf_stalls;
`endif

  fir_scie_sequencer dut (
    .clock(clock), .reset(reset),
    .io_cfg_valid(io_cfg_valid), .io_cfg_ready(io_cfg_ready),
    .io_cfg_idx(io_cfg_idx), .io_cfg_coef(io_cfg_coef),
    .io_in_valid(io_in_valid), .io_in_ready(io_in_ready), .io_in_sample(io_in_sample),
    .io_out_valid(io_out_valid), .io_out_ready(io_out_ready), .io_out_result(io_out_result),
    .io_scie_valid(io_scie_valid), .io_scie_insn(io_scie_insn),
    .io_scie_rs1(io_scie_rs1), .io_scie_rs2(io_scie_rs2), .io_scie_rd(io_scie_rd),
    .io_err(io_err)
`ifdef FIR_SEQ_PERF_EN
    , .io_perf_results(io_perf_results), .io_perf_stalls(io_perf_stalls)
`endif
  );

  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  // ---------------- SCIE FIR unit (environment) ----------------
  logic [31:0] fir_coef [8];
  logic [31:0] fir_win [NTAPS];
  logic [31:0] fir_acc = '0;
  logic [31:0] rd_reg = '0;
  assign io_scie_rd = rd_reg;

  initial begin
    for (int k = 0; k < 8; k++) fir_coef[k] = '0;
    for (int k = 0; k < NTAPS; k++) fir_win[k] = '0;
  end

  function automatic logic [31:0] fir_dot(input logic [31:0] s);
    logic [31:0] acc;
    acc = fir_coef[0] * s;
    for (int k = 1; k < NTAPS; k++) acc += fir_coef[k] * fir_win[k-1];
    return acc;
  endfunction

  always @(posedge clock) begin
    if (reset && io_scie_valid) begin
      case (io_scie_insn)
        I_LOAD: fir_coef[io_scie_rs2[2:0]] <= io_scie_rs1;
        I_PUSH: begin
          for (int k = NTAPS - 1; k > 0; k--) fir_win[k] <= fir_win[k-1];
          fir_win[0] <= io_scie_rs1;
          fir_acc    <= fir_dot(io_scie_rs1);
        end
        I_READ: rd_reg <= fir_acc;
        default: ;
      endcase
    end
  end

  // ---------------- reference model and scoreboard ----------------
  typedef struct { logic [31:0] val; int acc_cyc; bit chk_lat; } res_t;
  typedef struct { logic [31:0] insn; logic [31:0] rs1; logic [31:0] rs2; int at; } beat_t;
  res_t  exp_q[$];
  beat_t beat_q[$];
  logic [31:0] ref_coef [NTAPS];
  logic [31:0] ref_hist[$];

  int vectors = 0;
  int miscompares = 0;
  int results_seen = 0;
  int stall_cnt = 0;
  bit rnd_mode = 0;
  bit ready_ctl = 0;

  initial for (int k = 0; k < NTAPS; k++) ref_coef[k] = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d (0x%08h) expected %0d (0x%08h) @cyc %0d", name, act, act, exp, exp, cyc);
    end
  endtask

  task automatic fail_now(input string name);
    vectors++;
    miscompares++;
    $display("FAIL %s @cyc %0d", name, cyc);
  endtask

  // y[n] = sum_k c[k] * x[n-k], with the newest sample at the front of the history.
  function automatic logic [31:0] ref_push(input logic [31:0] s);
    logic [31:0] sum;
    ref_hist.push_front(s);
    if (ref_hist.size() > NTAPS) void'(ref_hist.pop_back());
    sum = '0;
    foreach (ref_hist[k]) sum += ref_coef[k] * ref_hist[k];
    return sum;
  endfunction

  always @(negedge clock) begin
    if (reset) begin
      if (io_in_valid && !io_in_ready) stall_cnt++;
      if (io_scie_valid) begin
        if (beat_q.size() == 0) fail_now("unexpected_beat");
        else begin
          beat_t b;
          b = beat_q.pop_front();
          chk("beat_insn", io_scie_insn, b.insn);
          chk("beat_rs1", io_scie_rs1, b.rs1);
          chk("beat_rs2", io_scie_rs2, b.rs2);
          chk("beat_cycle", 32'(cyc), 32'(b.at));
        end
      end else begin
        chk("idle_beat_zero", io_scie_insn | io_scie_rs1 | io_scie_rs2, 32'd0);
      end
      if (io_out_valid && io_out_ready) begin
        results_seen++;
        if (exp_q.size() == 0) fail_now("unexpected_result");
        else begin
          res_t e;
          e = exp_q.pop_front();
          $display("result %0d: got %0d expected %0d @cyc %0d", results_seen, io_out_result, e.val, cyc);
          chk("result", io_out_result, e.val);
          if (e.chk_lat) chk("out_latency", 32'(cyc - e.acc_cyc), 32'd5);
        end
      end
    end
  end

  always @(posedge clock) begin
    #2;
    io_out_ready = rnd_mode ? 1'($urandom_range(0, 1)) : ready_ctl;
  end

  // ---------------- drivers (called at posedge+1, return at posedge+1) ----------------
  task automatic idle(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic send_sample(input logic [31:0] s, input int max_wait, input bit lat,
                             output bit ok, output int acc_c);
    ok = 0;
    acc_c = 0;
    io_in_valid = 1'b1;
    io_in_sample = s;
    for (int i = 0; i < max_wait && !ok; i++) begin
      @(negedge clock);
      if (io_in_ready) begin
        ok = 1;
        acc_c = cyc;
        exp_q.push_back('{ref_push(s), cyc, lat});
        beat_q.push_back('{I_PUSH, s, 32'd0, cyc + 1});
        beat_q.push_back('{I_READ, 32'd0, 32'd0, cyc + 2 + PUSH_GAP});
      end
      @(posedge clock);
      #1;
    end
    io_in_valid = 1'b0;
    io_in_sample = '0;
  endtask

  task automatic send_cfg(input logic [IDXW-1:0] idx, input logic [31:0] coef, output bit ok);
    ok = 0;
    io_cfg_valid = 1'b1;
    io_cfg_idx = idx;
    io_cfg_coef = coef;
    for (int i = 0; i < 20 && !ok; i++) begin
      @(negedge clock);
      if (io_cfg_ready) begin
        ok = 1;
        if (32'(idx) < NTAPS) begin
          ref_coef[idx] = coef;
          beat_q.push_back('{I_LOAD, coef, 32'(idx), cyc + 1});
        end
      end
      @(posedge clock);
      #1;
    end
    io_cfg_valid = 1'b0;
    io_cfg_idx = '0;
    io_cfg_coef = '0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit ok;
    int acc_c;
    int seen_before;
    logic [31:0] coefs [5];
    logic [31:0] samps [5];
    coefs = '{54, 8, 24, 30, 79};
    samps = '{88, 36, 15, 95, 89};

    // reset phase
    @(negedge clock);
    chk("rst_cfg_ready", 32'(io_cfg_ready), 0);
    chk("rst_in_ready", 32'(io_in_ready), 0);
    chk("rst_out_valid", 32'(io_out_valid), 0);
    chk("rst_scie_valid", 32'(io_scie_valid), 0);
    chk("rst_scie_word", io_scie_insn | io_scie_rs1 | io_scie_rs2, 0);
    chk("rst_err", 32'(io_err), 0);
    repeat (3) @(posedge clock);
    #1 reset = 1'b1;
    @(negedge clock);
    chk("release_cfg_ready", 32'(io_cfg_ready), 0);
    chk("release_in_ready", 32'(io_in_ready), 0);
    @(negedge clock);
    chk("en_cfg_ready", 32'(io_cfg_ready), 1);
    chk("en_in_ready", 32'(io_in_ready), 1);
    @(posedge clock);
    #1;

    // coefficient loads
    for (int i = 0; i < NTAPS; i++) begin
      send_cfg(IDXW'(i), coefs[i], ok);
      chk("cfg_accept", 32'(ok), 1);
    end
    idle(2);

    // stream with consumer always ready
    ready_ctl = 1;
    idle(1);
    for (int i = 0; i < 5; i++) begin
      send_sample(samps[i], 40, 1'b1, ok, acc_c);
      chk("stream_accept", 32'(ok), 1);
    end
    idle(10);
    chk("stream_drained", 32'(exp_q.size()), 0);
`ifdef FIR_SEQ_PERF_EN
    chk("perf_results", io_perf_results, 32'd5);
    chk("perf_stalls", io_perf_stalls, 32'(stall_cnt));
`endif

    // backpressure: four fill the buffer, the fifth is blocked
    ready_ctl = 0;
    idle(2);
    for (int i = 0; i < 4; i++) begin
      send_sample($urandom_range(0, 500), 40, 1'b0, ok, acc_c);
      chk("bp_accept", 32'(ok), 1);
    end
    send_sample(32'd321, 30, 1'b0, ok, acc_c);
    chk("bp_blocked", 32'(ok), 0);
    chk("bp_out_valid", 32'(io_out_valid), 1);
    ready_ctl = 1;
    send_sample(32'd321, 40, 1'b0, ok, acc_c);
    chk("bp_resume5", 32'(ok), 1);
    send_sample(32'd77, 40, 1'b0, ok, acc_c);
    chk("bp_resume6", 32'(ok), 1);
    idle(15);
    chk("bp_drained", 32'(exp_q.size()), 0);

    // out-of-range coefficient index
    send_cfg(IDXW'(5), 32'd999, ok);
    chk("bad_idx_handshake", 32'(ok), 1);
    idle(2);
    chk("err_sticky", 32'(io_err), 1);
    send_sample(32'd42, 40, 1'b1, ok, acc_c);
    chk("post_err_accept", 32'(ok), 1);
    idle(8);

    // randomized mix with a random consumer
    rnd_mode = 1;
    for (int i = 0; i < 30; i++) begin
      if ($urandom_range(0, 3) == 0) begin
        send_cfg(IDXW'($urandom_range(0, NTAPS - 1)), $urandom_range(0, 1000), ok);
        chk("rnd_cfg_accept", 32'(ok), 1);
      end else begin
        send_sample($urandom, 80, 1'b0, ok, acc_c);
        chk("rnd_accept", 32'(ok), 1);
      end
      idle($urandom_range(0, 3));
    end
    rnd_mode = 0;
    idle(30);
    chk("rnd_drained", 32'(exp_q.size()), 0);
    chk("err_still_set", 32'(io_err), 1);

    // reset while the sample waits for its result
    send_sample(32'd11, 40, 1'b0, ok, acc_c);
    chk("rst_test_accept", 32'(ok), 1);
    for (int i = 0; i < 10 && cyc < acc_c + 4; i++) begin
      @(posedge clock);
      #1;
    end
    seen_before = results_seen;
    exp_q.delete();
    beat_q.delete();
    reset = 1'b0;
    #1;
    chk("midrst_scie_valid", 32'(io_scie_valid), 0);
    chk("midrst_out_valid", 32'(io_out_valid), 0);
    chk("midrst_err", 32'(io_err), 0);
    repeat (3) @(posedge clock);
    #1 reset = 1'b1;
    idle(20);
    chk("no_result_after_reset", 32'(results_seen), 32'(seen_before));
    chk("ready_after_reset", 32'(io_in_ready), 1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
